// File: rtl/midi_note_tracker_pkg.sv
// midi_note_tracker_pkg: shared MIDI status codes, parser states and stack ops.
// Ports: none (package).
package midi_note_tracker_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHPRESS  = 4'hD;

    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2,
        ST_SYSEX
    } parse_state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_REMOVE,
        OP_CLEAR
    } stack_op_e;

    // Voice messages carry two data bytes except program change
    // and channel pressure.
    function automatic logic has_two_data(input logic [3:0] hi);
        return !(hi == PROG || hi == CHPRESS);
    endfunction

endpackage

// File: rtl/midi_note_stack.sv
// midi_note_stack: last-note-priority stack of held keys, entry 0 is newest.
// Ports: clk/rst_n, i_op/i_note/i_vel op request; o_top_* newest entry,
//        o_empty, o_top_changed (push, or top changed while non-empty).
module midi_note_stack
    import midi_note_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  stack_op_e i_op,
    input  logic [6:0] i_note,
    input  logic [6:0] i_vel,
    output logic [6:0] o_top_note,
    output logic [6:0] o_top_vel,
    output logic       o_empty,
    output logic       o_top_changed
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_vld;
    logic [6:0]       r_note [DEPTH];
    logic [6:0]       r_vel  [DEPTH];
    logic             r_evt;

    logic [DEPTH-1:0] w_vld;
    logic [6:0]       w_note [DEPTH];
    logic [6:0]       w_vel  [DEPTH];
    logic             w_evt;
    logic             w_hit;
    logic [IW-1:0]    w_idx;

    // Held notes are unique, so at most one entry matches.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_vld[i] && r_note[i] == i_note) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_vld  = r_vld;
        w_note = r_note;
        w_vel  = r_vel;
        w_evt  = 1'b0;
        unique case (i_op)
            OP_PUSH: begin
                // Shift down to the slot of a retriggered note; entries
                // below it stay. Without a hit the oldest falls off.
                for (int i = 1; i < DEPTH; i++) begin
                    if (!(w_hit && i > int'(w_idx))) begin
                        w_vld[i]  = r_vld[i-1];
                        w_note[i] = r_note[i-1];
                        w_vel[i]  = r_vel[i-1];
                    end
                end
                w_vld[0]  = 1'b1;
                w_note[0] = i_note;
                w_vel[0]  = i_vel;
                w_evt     = 1'b1;
            end
            OP_REMOVE: begin
                if (w_hit) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (i >= int'(w_idx)) begin
                            w_vld[i]  = r_vld[i+1];
                            w_note[i] = r_note[i+1];
                            w_vel[i]  = r_vel[i+1];
                        end
                    end
                    w_vld[DEPTH-1] = 1'b0;
                    w_evt = (w_idx == '0) && w_vld[0];
                end
            end
            OP_CLEAR: begin
                w_vld = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_evt <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
            end
        end else begin
            r_vld  <= w_vld;
            r_note <= w_note;
            r_vel  <= w_vel;
            r_evt  <= w_evt;
        end
    end

    assign o_top_note    = r_note[0];
    assign o_top_vel     = r_vel[0];
    assign o_empty       = ~|r_vld;
    assign o_top_changed = r_evt;

endmodule

// File: rtl/midi_note_tracker.sv
// midi_note_tracker: MIDI byte parser with running status feeding a note stack.
// Ports: clk/rst_n; rx_data/rx_valid byte in; note/velocity/note_valid/gate
//        monophonic output; parse_err data byte without running status.
module midi_note_tracker
    import midi_note_tracker_pkg::*;
#(
    parameter logic [3:0] CHANNEL     = 4'd0,
    parameter bit         OMNI        = 1'b0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] note,
    output logic [6:0] velocity,
    output logic       note_valid,
    output logic       gate,
    output logic       parse_err
);

    parse_state_e r_state;
    logic [7:0]   r_status;
    logic         r_rs_valid;
    logic [6:0]   r_d1;
    logic         r_parse_err;
    logic [6:0]   r_note;
    logic [6:0]   r_vel;
    logic         r_note_valid;
    logic         r_gate;

    logic       w_rt;
    logic       w_voice;
    logic       w_d1;
    logic       w_d2;
    logic       w_ch_ok;
    stack_op_e  w_op;
    logic [6:0] w_top_note;
    logic [6:0] w_top_vel;
    logic       w_empty;
    logic       w_top_changed;

    assign w_rt    = rx_data >= RT_MIN;
    assign w_voice = rx_data[7] && (rx_data < SYSEX);
    // An idle parser with running status takes a data byte as byte 1.
    assign w_d1    = rx_valid && !rx_data[7] &&
                     (r_state == ST_DATA1 ||
                      (r_state == ST_IDLE && r_rs_valid));
    assign w_d2    = rx_valid && !rx_data[7] && (r_state == ST_DATA2);
    assign w_ch_ok = OMNI || (r_status[3:0] == CHANNEL);

    always_comb begin
        w_op = OP_NONE;
        if (w_d2 && w_ch_ok) begin
            unique case (r_status[7:4])
                NOTE_ON:
                    w_op = (rx_data[6:0] != '0) ? OP_PUSH : OP_REMOVE;
                NOTE_OFF:
                    w_op = OP_REMOVE;
                CC:
                    if (r_d1 == CC_ALL_NOTES_OFF ||
                        r_d1 == CC_ALL_SOUND_OFF)
                        w_op = OP_CLEAR;
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_status    <= '0;
            r_rs_valid  <= 1'b0;
            r_d1        <= '0;
            r_parse_err <= 1'b0;
        end else begin
            r_parse_err <= 1'b0;
            if (rx_valid && !w_rt) begin
                if (r_state == ST_SYSEX) begin
                    if (rx_data == EOX) begin
                        r_state    <= ST_IDLE;
                        r_rs_valid <= 1'b0;
                    end else if (w_voice) begin
                        r_status   <= rx_data;
                        r_rs_valid <= 1'b1;
                        r_state    <= ST_DATA1;
                    end
                end else if (w_voice) begin
                    r_status   <= rx_data;
                    r_rs_valid <= 1'b1;
                    r_state    <= ST_DATA1;
                end else if (rx_data == SYSEX) begin
                    r_state    <= ST_SYSEX;
                    r_rs_valid <= 1'b0;
                end else if (rx_data[7]) begin
                    r_state    <= ST_IDLE;
                    r_rs_valid <= 1'b0;
                end else if (w_d1) begin
                    r_d1    <= rx_data[6:0];
                    r_state <= has_two_data(r_status[7:4]) ?
                               ST_DATA2 : ST_IDLE;
                end else if (w_d2) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_parse_err <= 1'b1;
                end
            end
        end
    end

    midi_note_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_op         (w_op),
        .i_note       (r_d1),
        .i_vel        (rx_data[6:0]),
        .o_top_note   (w_top_note),
        .o_top_vel    (w_top_vel),
        .o_empty      (w_empty),
        .o_top_changed(w_top_changed)
    );

    // On an emptied stack note/velocity keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note       <= '0;
            r_vel        <= '0;
            r_note_valid <= 1'b0;
            r_gate       <= 1'b0;
        end else begin
            r_gate       <= !w_empty;
            r_note_valid <= w_top_changed;
            if (w_top_changed) begin
                r_note <= w_top_note;
                r_vel  <= w_top_vel;
            end
        end
    end

    assign note       = {1'b0, r_note};
    assign velocity   = r_vel;
    assign note_valid = r_note_valid;
    assign gate       = r_gate;
    assign parse_err  = r_parse_err;

endmodule
